conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 113 +++++++++++
 tb/tb_conv_window_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 register
// window turn a raster-order pixel stream into valid-convolution windows.
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module conv_window_gen #(
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_LENGTH = 3,
    parameter int MAP_WIDTH     = 8,
    parameter int MAP_HEIGHT    = 8
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [`DATA_SIZE-1:0]                            pix_in,
    input  logic                                             pix_valid,
    output logic                                             pix_ready,
    output logic [KERNEL_WIDTH*KERNEL_LENGTH*`DATA_SIZE-1:0] map_out,
    output logic                                             win_valid,
    input  logic                                             win_ready,
    output logic                                             frame_done
);
    localparam int D  = `DATA_SIZE;
    localparam int CW = $clog2(MAP_WIDTH);
    localparam int RW = $clog2(MAP_HEIGHT);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        WRAP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic          accept;
    logic          last_win;
    logic [D-1:0]  win [3][3];
    logic [D-1:0]  lb0 [MAP_WIDTH];
    logic [D-1:0]  lb1 [MAP_WIDTH];

    assign pix_ready = rst_n & (~win_valid | win_ready);
    assign accept    = pix_valid & pix_ready;

    // state classifies the pixel that will be accepted next
    always_comb begin
        col_nxt   = col;
        row_nxt   = row;
        state_nxt = state;
        if (accept) begin
            if (col == CW'(MAP_WIDTH - 1)) begin
                col_nxt = '0;
                row_nxt = (row == RW'(MAP_HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
                col_nxt = col + 1'b1;
            end
            if (row_nxt < RW'(2) || col_nxt < CW'(2))
                state_nxt = FILL;
            else if (row_nxt == RW'(MAP_HEIGHT - 1) && col_nxt == CW'(MAP_WIDTH - 1))
                state_nxt = WRAP;
            else
                state_nxt = STREAM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            last_win   <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            frame_done <= win_valid & win_ready & last_win;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1[col];
                win[1][2] <= lb0[col];
                win[2][2] <= pix_in;
            end
            // a window-producing pixel can only be accepted when the slot is free
            if (accept && state != FILL) begin
                win_valid <= 1'b1;
                last_win  <= (state == WRAP);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    // Line buffers are never cleared; FILL keeps their stale rows out of map_out.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_map
        assign map_out[D*(9-k)-1 -: D] = win[k/3][k%3];
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 4x4 and 8x8 instances driven through one muxed
// stimulus port, checked against a window list computed from whole frames.
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module tb_conv_window_gen;
    localparam int D  = `DATA_SIZE;
    localparam int MW = 9 * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [D-1:0]  pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          sel = 1'b0;
    logic          wr_rand = 1'b0;
    logic          pv4, pv8, pr4, pr8, wv4, wv8, fd4, fd8;
    logic [MW-1:0] mo4, mo8;
    logic          pr, wv, fd;
    logic [MW-1:0] map_out;

    assign pv4     = pix_valid & ~sel;
    assign pv8     = pix_valid & sel;
    assign pr      = sel ? pr8 : pr4;
    assign wv      = sel ? wv8 : wv4;
    assign fd      = sel ? fd8 : fd4;
    assign map_out = sel ? mo8 : mo4;

    conv_window_gen #(.KERNEL_WIDTH(3), .KERNEL_LENGTH(3), .MAP_WIDTH(4), .MAP_HEIGHT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pv4), .pix_ready(pr4),
        .map_out(mo4), .win_valid(wv4), .win_ready(win_ready), .frame_done(fd4)
    );

    conv_window_gen #(.KERNEL_WIDTH(3), .KERNEL_LENGTH(3), .MAP_WIDTH(8), .MAP_HEIGHT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pv8), .pix_ready(pr8),
        .map_out(mo8), .win_valid(wv8), .win_ready(win_ready), .frame_done(fd8)
    );

    int            checks = 0;
    int            errors = 0;
    logic [MW-1:0] exp_q[$];
    logic          last_q[$];

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: every full 3x3 neighbourhood of the frame, in raster order of its bottom-right pixel.
    task automatic model_frame(input int w, input int h, input int px[$]);
        logic [MW-1:0] v;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                v = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        v = (v << D) | MW'(px[(r-2+i)*w + (c-2+j)] & ((1 << D) - 1));
                exp_q.push_back(v);
                last_q.push_back(r == h - 1 && c == w - 1);
            end
        end
    endtask

    task automatic send_pix(input logic [D-1:0] v, input int gap);
        int n;
        pix_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        pix_valid = 1'b1;
        pix_in    = v;
        n = 0;
        forever begin
            @(negedge clk);
            if (pr) break;
            n++;
            if (n > 500) begin
                check("pix_timeout", MW'(1'b0), MW'(1'b1));
                break;
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int px[$], input int max_gap);
        model_frame(w, h, px);
        for (int i = 0; i < w * h; i++)
            send_pix(D'(px[i]), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        check("drain_empty", MW'(exp_q.size()), MW'(0));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    logic          exp_fd = 1'b0;
    logic          stall_prev = 1'b0;
    logic [MW-1:0] held = '0;
    int            win_cnt = 0;
    int            fd_cnt = 0;

    always @(negedge clk) begin
        check("pix_ready", MW'(pr), MW'(rst_n & (~wv | win_ready)));
        check("frame_done", MW'(fd), MW'(exp_fd));
        if (fd) fd_cnt++;
        if (stall_prev) begin
            check("stall_valid", MW'(wv), MW'(1'b1));
            check("stall_map", map_out, held);
        end
        exp_fd = 1'b0;
        if (!rst_n) begin
            check("reset_win_valid", MW'(wv), MW'(1'b0));
        end else if (wv && win_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_window", MW'(1'b1), MW'(1'b0));
            end else begin
                check("window", map_out, exp_q.pop_front());
                exp_fd = last_q.pop_front();
                win_cnt++;
            end
        end
        stall_prev = rst_n && wv && !win_ready;
        held       = map_out;
    end

    always begin
        @(posedge clk); #1;
        if (wr_rand) win_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic end_test(input string tag, input int w0, input int f0, input int exp_w, input int exp_f);
        check({tag, "_windows"}, MW'(win_cnt - w0), MW'(exp_w));
        check({tag, "_frame_done"}, MW'(fd_cnt - f0), MW'(exp_f));
    endtask

    int px[$];
    int px2[$];
    int w0, f0, n;

    initial begin
        @(negedge clk);
        check("rst_valid4", MW'(wv4), MW'(1'b0));
        check("rst_valid8", MW'(wv8), MW'(1'b0));
        check("rst_done4", MW'(fd4), MW'(1'b0));
        check("rst_map4", mo4, MW'(0));
        check("rst_map8", mo8, MW'(0));
        check("rst_ready4", MW'(pr4), MW'(1'b0));
        check("rst_ready8", MW'(pr8), MW'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        win_ready = 1'b1;
        for (int i = 1; i <= 16; i++) px.push_back(i);
        for (int i = 101; i <= 116; i++) px2.push_back(i);

        // single 4x4 frame, always ready
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(4, 4, px, 0);
        drain();
        end_test("frame4", w0, f0, 4, 1);

        // consumer stalls right after the first window
        w0 = win_cnt; f0 = fd_cnt;
        win_ready = 1'b0;
        fork
            send_frame(4, 4, px, 0);
            begin
                n = 0;
                while (!wv && n < 200) begin @(negedge clk); n++; end
                check("stall_seen", MW'(wv), MW'(1'b1));
                repeat (5) begin
                    @(negedge clk);
                    check("stall_pix_ready", MW'(pr), MW'(1'b0));
                end
                @(posedge clk); #1;
                win_ready = 1'b1;
            end
        join
        drain();
        end_test("stall4", w0, f0, 4, 1);

        // two frames back to back
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(4, 4, px, 0);
        send_frame(4, 4, px2, 0);
        drain();
        end_test("b2b4", w0, f0, 8, 2);

        // reset in the middle of a frame
        w0 = win_cnt; f0 = fd_cnt;
        for (int i = 1; i <= 7; i++) send_pix(D'(i), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", MW'(wv), MW'(1'b0));
        check("midrst_ready", MW'(pr), MW'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(4, 4, px, 0);
        drain();
        end_test("reset4", w0, f0, 4, 1);

        // 8x8 random data with random input gaps and consumer stalls
        sel = 1'b1;
        px.delete();
        for (int i = 0; i < 64; i++) px.push_back(int'($urandom_range(0, (1 << D) - 1)));
        w0 = win_cnt; f0 = fd_cnt;
        wr_rand = 1'b1;
        send_frame(8, 8, px, 2);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        wr_rand = 1'b0;
        win_ready = 1'b1;
        drain();
        end_test("rand8", w0, f0, 36, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
